mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: width of samples, coefficients and MAC operands/result.
REQ-002 Parameter TAPS, default 4 (range 2..64): number of taps in the delay line and coefficient bank.
REQ-003 Clk_CI  in  1: single clock; all state updates on its rising edge.
REQ-004 Rst_RBI  in  1: reset, synchronous and active-low.
REQ-005 Smp_DI  in  WIDTH / Smp_Valid_SI  in  1 / Smp_Ready_SO  out  1: sample input handshake.
REQ-006 Coef_WrEn_SI  in  1 / Coef_Addr_SI  in  clog2(TAPS) / Coef_DI  in  WIDTH: coefficient write port.
REQ-007 Coef_Err_SO  out  1: one-cycle pulse when a coefficient write is dropped.
REQ-008 Mac_Clr_SO, Mac_WrEn_SO  out  1 each; Mac_In0_DO, Mac_In1_DO  out  WIDTH each; Mac_Out_DI  in  WIDTH: MAC drive/return port.
REQ-009 Res_DO  out  WIDTH / Res_Valid_SO  out  1 / Res_Ready_SI  in  1: result output handshake.

Function
REQ-010 FSM states: IDLE, CLEAR, ACCUM, DRAIN, RESULT.
REQ-011 Smp_Ready_SO shall be 1 only in IDLE; a sample is accepted when Smp_Valid_SI and Smp_Ready_SO are both 1.
REQ-012 On acceptance, the delay line shifts: tap[0] <= Smp_DI, tap[k] <= tap[k-1]; the FSM goes to CLEAR.
REQ-013 CLEAR lasts 1 cycle: Mac_Clr_SO=1, Mac_WrEn_SO=1, operands 0; next state ACCUM, tap counter k=0.
REQ-014 ACCUM lasts exactly TAPS cycles: Mac_WrEn_SO=1, Mac_Clr_SO=0, Mac_In0_DO=tap[k], Mac_In1_DO=coef[k], k increments; exit to DRAIN after k=TAPS-1.
REQ-015 DRAIN lasts 1 cycle: Mac_WrEn_SO=0, operands 0; Res_DO register <= Mac_Out_DI; next state RESULT.
REQ-016 RESULT: Res_Valid_SO=1 and Res_DO stable until Res_Ready_SI=1, then IDLE on the next edge.
REQ-017 Latency: sample accepted at edge t gives Res_Valid_SO=1 from cycle t+TAPS+3; peak throughput is one result per TAPS+4 cycles with Res_Ready_SI held at 1.
REQ-018 Outside CLEAR and ACCUM, Mac_WrEn_SO=0, Mac_Clr_SO=0 and both operands are 0.
REQ-019 A coefficient write in IDLE shall update coef[Coef_Addr_SI] at the edge.
REQ-020 A coefficient write in any other state shall be dropped and Coef_Err_SO pulsed for 1 cycle.
REQ-021 A write with Coef_Addr_SI >= TAPS shall be dropped and Coef_Err_SO pulsed for 1 cycle.
REQ-022 When a sample is accepted and a coefficient is written in the same IDLE cycle, the write takes effect and the run uses the new coefficient.
REQ-023 Smp_Valid_SI asserted outside IDLE shall not be accepted and shall not alter the delay line.

Reset
REQ-024 With Rst_RBI=0 at an edge: FSM=IDLE, all taps=0, all coefficients=0, Res_DO=0.
REQ-025 With Rst_RBI=0 at an edge: Res_Valid_SO=0, Coef_Err_SO=0, all Mac_* outputs=0.
REQ-026 Reset mid-run (any state) shall abort the run; no Res_Valid_SO pulse shall follow.

Configuration
REQ-027 Macro MAC_SEQ_FLUSH_EN: when defined, the block shall add input Flush_SI (1 bit).
REQ-028 With MAC_SEQ_FLUSH_EN defined, Flush_SI=1 in IDLE shall zero all taps at the edge and keep coefficients.
REQ-029 With MAC_SEQ_FLUSH_EN defined, Flush_SI=1 in IDLE takes priority over a simultaneous sample acceptance: Smp_Ready_SO=0 that cycle.
REQ-030 With MAC_SEQ_FLUSH_EN defined, Flush_SI is ignored outside IDLE.
REQ-031 Without MAC_SEQ_FLUSH_EN, there is no Flush_SI port and taps are cleared only by reset.

Verification (WIDTH=8, TAPS=4, reference MAC model attached)
REQ-032 Test 1: reset, write coef[0..3]=0x40, send sample 0x40 -> Mac_Clr_SO one cycle, 4 WrEn cycles, Res_DO=0x10, Res_Valid_SO at t+7.
REQ-033 Test 2: then send 0x40, 0x40, 0x40 back-to-back with Res_Ready_SI=1 -> Res_DO 0x20, 0x30, 0x40; results spaced 8 cycles apart.
REQ-034 Test 3: hold Res_Ready_SI=0 for 10 cycles in RESULT -> Res_DO stable, Smp_Ready_SO=0, offered sample not taken.
REQ-035 Test 4: coefficient write during ACCUM, and a write to addr 5 in IDLE -> Coef_Err_SO pulses for each, coefficient bank unchanged.
REQ-036 Test 5: Rst_RBI=0 during ACCUM -> IDLE next cycle, all outputs 0, no result issued.
REQ-037 Test 6 (MAC_SEQ_FLUSH_EN): Flush_SI pulse, then sample 0x40 -> Res_DO=0x10.

Source files
------------

// File: rtl/mac_sequencer_if.sv
// Bundled handshake/bus signals of mac_sequencer: sample input, coefficient write port,
// external MAC drive/return and result output. The sequencer uses master, its environment slave.
interface mac_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAPS  = 4
);
  // One spare address bit so out-of-range writes are visible even for power-of-two TAPS.
  localparam int unsigned AddrW = $clog2(TAPS) + 1;

  logic [WIDTH-1:0] Smp_DI;
  logic             Smp_Valid_SI;
  logic             Smp_Ready_SO;

  logic             Coef_WrEn_SI;
  logic [AddrW-1:0] Coef_Addr_SI;
  logic [WIDTH-1:0] Coef_DI;
  logic             Coef_Err_SO;

  logic             Mac_Clr_SO;
  logic             Mac_WrEn_SO;
  logic [WIDTH-1:0] Mac_In0_DO;
  logic [WIDTH-1:0] Mac_In1_DO;
  logic [WIDTH-1:0] Mac_Out_DI;

  logic [WIDTH-1:0] Res_DO;
  logic             Res_Valid_SO;
  logic             Res_Ready_SI;

  modport master (
    input  Smp_DI, Smp_Valid_SI, Coef_WrEn_SI, Coef_Addr_SI, Coef_DI, Mac_Out_DI, Res_Ready_SI,
    output Smp_Ready_SO, Coef_Err_SO, Mac_Clr_SO, Mac_WrEn_SO, Mac_In0_DO, Mac_In1_DO,
           Res_DO, Res_Valid_SO
  );

  modport slave (
    output Smp_DI, Smp_Valid_SI, Coef_WrEn_SI, Coef_Addr_SI, Coef_DI, Mac_Out_DI, Res_Ready_SI,
    input  Smp_Ready_SO, Coef_Err_SO, Mac_Clr_SO, Mac_WrEn_SO, Mac_In0_DO, Mac_In1_DO,
           Res_DO, Res_Valid_SO
  );
endinterface

// File: rtl/mac_sequencer.sv
// FIR-style sequencer: shifts samples into a delay line and drives an external MAC once per tap.
// Optional tap flush input is enabled by defining MAC_SEQ_FLUSH_EN.
module mac_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAPS  = 4
) (
  input logic             Clk_CI,
  input logic             Rst_RBI,
`ifdef MAC_SEQ_FLUSH_EN
  input logic             Flush_SI,
`endif
  mac_sequencer_if.master bus
);
  localparam int unsigned AddrW = $clog2(TAPS) + 1;
  localparam int unsigned CntW  = $clog2(TAPS);

  typedef enum logic [2:0] {StIdle, StClear, StAccum, StDrain, StResult} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] tap_q  [TAPS];
  logic [WIDTH-1:0] coef_q [TAPS];
  logic [WIDTH-1:0] res_q;
  logic             coef_err_q;

  logic            flush;
  logic            smp_acc;
  logic            coef_in_range;
  logic            coef_ok;
  logic            coef_bad;
  logic [CntW-1:0] coef_idx;

`ifdef MAC_SEQ_FLUSH_EN
  assign flush = Flush_SI & (state_q == StIdle);
`else
  assign flush = 1'b0;
`endif

  assign bus.Smp_Ready_SO = (state_q == StIdle) & ~flush;
  assign smp_acc          = bus.Smp_Valid_SI & bus.Smp_Ready_SO;

  assign coef_in_range = bus.Coef_Addr_SI < AddrW'(TAPS);
  assign coef_ok       = bus.Coef_WrEn_SI & (state_q == StIdle) & coef_in_range;
  assign coef_bad      = bus.Coef_WrEn_SI & ~coef_ok;
  assign coef_idx      = bus.Coef_Addr_SI[CntW-1:0];

  assign bus.Res_DO       = res_q;
  assign bus.Res_Valid_SO = (state_q == StResult);
  assign bus.Coef_Err_SO  = coef_err_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus.Mac_Clr_SO  = 1'b0;
    bus.Mac_WrEn_SO = 1'b0;
    bus.Mac_In0_DO  = '0;
    bus.Mac_In1_DO  = '0;
    unique case (state_q)
      StIdle: begin
        if (smp_acc) state_d = StClear;
      end
      StClear: begin
        bus.Mac_Clr_SO  = 1'b1;
        bus.Mac_WrEn_SO = 1'b1;
        cnt_d           = '0;
        state_d         = StAccum;
      end
      StAccum: begin
        bus.Mac_WrEn_SO = 1'b1;
        bus.Mac_In0_DO  = tap_q[cnt_q];
        bus.Mac_In1_DO  = coef_q[cnt_q];
        cnt_d           = cnt_q + 1'b1;
        if (cnt_q == CntW'(TAPS - 1)) state_d = StDrain;
      end
      StDrain: begin
        state_d = StResult;
      end
      StResult: begin
        if (bus.Res_Ready_SI) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      res_q      <= '0;
      coef_err_q <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
        tap_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      coef_err_q <= coef_bad;
      // Flush wins over a sample; Smp_Ready_SO is already low in that case.
      if (flush) begin
        for (int i = 0; i < int'(TAPS); i++) tap_q[i] <= '0;
      end else if (smp_acc) begin
        tap_q[0] <= bus.Smp_DI;
        for (int i = 1; i < int'(TAPS); i++) tap_q[i] <= tap_q[i-1];
      end
      if (coef_ok) coef_q[coef_idx] <= bus.Coef_DI;
      if (state_q == StDrain) res_q <= bus.Mac_Out_DI;
    end
  end
endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized self-checking bench for mac_sequencer with a Q0.8 MAC attached to the MAC port.
// Flush test runs only when MAC_SEQ_FLUSH_EN is defined.
module tb_mac_sequencer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned TAPS  = 4;

  logic clk;
  logic rst_n;
`ifdef MAC_SEQ_FLUSH_EN
  logic flush;
`endif

  mac_sequencer_if #(.WIDTH(WIDTH), .TAPS(TAPS)) bus ();

  mac_sequencer #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
    .Clk_CI  (clk),
    .Rst_RBI (rst_n),
`ifdef MAC_SEQ_FLUSH_EN
    .Flush_SI(flush),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC accumulates the upper byte of each product.
  function automatic logic [7:0] mul_hi(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, b};
    return p[15:8];
  endfunction

  logic [7:0] mac_acc;
  always @(posedge clk) begin
    if (!rst_n) mac_acc <= '0;
    else if (bus.Mac_WrEn_SO) mac_acc <= bus.Mac_Clr_SO ? 8'h00
                                        : mac_acc + mul_hi(bus.Mac_In0_DO, bus.Mac_In1_DO);
  end
  assign bus.Mac_Out_DI = mac_acc;

  // Reference state: what the delay line and coefficient bank should hold.
  logic [7:0] ref_tap  [TAPS];
  logic [7:0] ref_coef [TAPS];
  logic [7:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_result();
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < int'(TAPS); k++) s += mul_hi(ref_tap[k], ref_coef[k]);
    return s;
  endfunction

  task automatic model_push(input logic [7:0] d);
    for (int k = int'(TAPS) - 1; k > 0; k--) ref_tap[k] = ref_tap[k-1];
    ref_tap[0] = d;
  endtask

  task automatic model_clear_all();
    for (int k = 0; k < int'(TAPS); k++) begin
      ref_tap[k]  = '0;
      ref_coef[k] = '0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear_all();
    check_eq("rst_valid", 32'(bus.Res_Valid_SO), 32'd0);
    check_eq("rst_res", 32'(bus.Res_DO), 32'd0);
    check_eq("rst_ready", 32'(bus.Smp_Ready_SO), 32'd1);
    check_eq("rst_mac", {bus.Mac_Clr_SO, bus.Mac_WrEn_SO, bus.Mac_In0_DO, bus.Mac_In1_DO}, 32'd0);
    check_eq("rst_err", 32'(bus.Coef_Err_SO), 32'd0);
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [7:0] d);
    bus.Coef_WrEn_SI = 1'b1;
    bus.Coef_Addr_SI = a;
    bus.Coef_DI      = d;
    @(negedge clk);
    bus.Coef_WrEn_SI = 1'b0;
    check_eq("coef_err_idle", 32'(bus.Coef_Err_SO), (32'(a) >= TAPS) ? 32'd1 : 32'd0);
    if (32'(a) < TAPS) ref_coef[a[1:0]] = d;
  endtask

  // Starts in IDLE at a negedge; returns once the result has been taken and the FSM is idle.
  task automatic run_sample(input logic [7:0] d, input bit wr, input logic [2:0] wa,
                            input logic [7:0] wd, input int inj, input int stall,
                            input bit offer, output logic [7:0] res);
    int cyc = 0, clr_n = 0, acc_n = 0, op_bad = 0, out_bad = 0;
    bit got = 1'b0;
    logic [7:0] exp;
    bus.Smp_Valid_SI = 1'b1;
    bus.Smp_DI       = d;
    bus.Res_Ready_SI = 1'b0;
    if (wr) begin
      bus.Coef_WrEn_SI = 1'b1;
      bus.Coef_Addr_SI = wa;
      bus.Coef_DI      = wd;
      if (32'(wa) < TAPS) ref_coef[wa[1:0]] = wd;
    end
    check_eq("smp_ready", 32'(bus.Smp_Ready_SO), 32'd1);
    model_push(d);
    exp = model_result();
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.Smp_Valid_SI = 1'b0;
      bus.Coef_WrEn_SI = 1'b0;
      if (cyc == inj) begin
        bus.Coef_WrEn_SI = 1'b1;
        bus.Coef_Addr_SI = 3'd0;
        bus.Coef_DI      = 8'hFF;
      end
      if (cyc == inj + 1) check_eq("coef_err_busy", 32'(bus.Coef_Err_SO), 32'd1);
      if (wr && cyc == 1)
        check_eq("coef_err_same", 32'(bus.Coef_Err_SO), (32'(wa) >= TAPS) ? 32'd1 : 32'd0);
      if (bus.Mac_Clr_SO) begin
        clr_n++;
        if (bus.Mac_In0_DO != 0 || bus.Mac_In1_DO != 0 || !bus.Mac_WrEn_SO) out_bad++;
      end
      if (bus.Mac_WrEn_SO && !bus.Mac_Clr_SO) begin
        if (acc_n < int'(TAPS) && (bus.Mac_In0_DO !== ref_tap[acc_n] ||
                                   bus.Mac_In1_DO !== ref_coef[acc_n])) op_bad++;
        acc_n++;
      end
      if (!bus.Mac_WrEn_SO && (bus.Mac_Clr_SO || bus.Mac_In0_DO != 0 || bus.Mac_In1_DO != 0))
        out_bad++;
      if (bus.Res_Valid_SO) got = 1'b1;
    end
    bus.Coef_WrEn_SI = 1'b0;
    check_eq("res_seen", 32'(got), 32'd1);
    check_eq("latency", 32'(cyc), TAPS + 3);
    check_eq("clr_cycles", 32'(clr_n), 32'd1);
    check_eq("acc_cycles", 32'(acc_n), TAPS);
    check_eq("mac_operands", 32'(op_bad), 32'd0);
    check_eq("mac_quiet", 32'(out_bad), 32'd0);
    check_eq("res_value", 32'(bus.Res_DO), 32'(exp));
    res = bus.Res_DO;
    for (int i = 0; i < stall; i++) begin
      if (offer) begin
        bus.Smp_Valid_SI = 1'b1;
        bus.Smp_DI       = 8'($urandom);
      end
      @(negedge clk);
      check_eq("stall_valid", 32'(bus.Res_Valid_SO), 32'd1);
      check_eq("stall_res", 32'(bus.Res_DO), 32'(exp));
      check_eq("stall_ready", 32'(bus.Smp_Ready_SO), 32'd0);
    end
    bus.Smp_Valid_SI = 1'b0;
    bus.Res_Ready_SI = 1'b1;
    @(negedge clk);
    bus.Res_Ready_SI = 1'b0;
    check_eq("back_idle", {31'd0, bus.Smp_Ready_SO & ~bus.Res_Valid_SO}, 32'd1);
  endtask

  logic [7:0] res;
  int cyc, last, n_acc, n_res, seen;

  initial begin
    rst_n            = 1'b0;
    bus.Smp_DI       = '0;
    bus.Smp_Valid_SI = 1'b0;
    bus.Coef_WrEn_SI = 1'b0;
    bus.Coef_Addr_SI = '0;
    bus.Coef_DI      = '0;
    bus.Res_Ready_SI = 1'b0;
`ifdef MAC_SEQ_FLUSH_EN
    flush            = 1'b0;
`endif
    model_clear_all();
    @(negedge clk);
    apply_reset();

    // Unit coefficients (0x40 = 0.25), single sample.
    for (int k = 0; k < int'(TAPS); k++) write_coef(3'(k), 8'h40);
    run_sample(8'h40, 1'b0, 3'd0, 8'h00, -1, 0, 1'b0, res);
    check_eq("t1_res", 32'(res), 32'h10);

    // Back-to-back samples with Res_Ready_SI held high.
    bus.Smp_DI = 8'h40; bus.Smp_Valid_SI = 1'b1; bus.Res_Ready_SI = 1'b1;
    n_acc = 0; n_res = 0; last = 0; cyc = 0;
    while (n_res < 3 && cyc < 60) begin
      if (bus.Smp_Valid_SI && bus.Smp_Ready_SO) begin
        model_push(8'h40);
        exp_q.push_back(model_result());
        n_acc++;
      end
      @(negedge clk);
      cyc++;
      if (n_acc == 3) bus.Smp_Valid_SI = 1'b0;
      if (bus.Res_Valid_SO) begin
        if (exp_q.size() > 0) check_eq("b2b_res", 32'(bus.Res_DO), 32'(exp_q.pop_front()));
        check_eq("b2b_const", 32'(bus.Res_DO), 32'(8'h10 * (n_res + 2)));
        if (n_res > 0) check_eq("b2b_gap", 32'(cyc - last), TAPS + 4);
        last = cyc;
        n_res++;
      end
    end
    check_eq("b2b_count", 32'(n_res), 32'd3);
    @(negedge clk);
    bus.Res_Ready_SI = 1'b0;

    // Stall in RESULT for 10 cycles while a sample is offered.
    run_sample(8'h40, 1'b0, 3'd0, 8'h00, -1, 10, 1'b1, res);
    check_eq("t3_res", 32'(res), 32'h40);

    // Dropped coefficient writes: one during ACCUM, one out of range in IDLE.
    run_sample(8'h40, 1'b0, 3'd0, 8'h00, 3, 0, 1'b0, res);
    check_eq("t4_res_busy", 32'(res), 32'h40);
    write_coef(3'd5, 8'h11);
    run_sample(8'h40, 1'b0, 3'd0, 8'h00, -1, 0, 1'b0, res);
    check_eq("t4_res_bank", 32'(res), 32'h40);

    // Randomized runs: random coefficients, same-cycle writes, stalls.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) write_coef(3'($urandom_range(0, 7)), 8'($urandom));
      run_sample(8'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 8'($urandom), -1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), res);
    end

    // Reset during ACCUM aborts the run.
    bus.Smp_DI = 8'h5A; bus.Smp_Valid_SI = 1'b1;
    @(negedge clk);
    bus.Smp_Valid_SI = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t5_in_accum", 32'(bus.Mac_WrEn_SO & ~bus.Mac_Clr_SO), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear_all();
    check_eq("t5_idle", 32'(bus.Smp_Ready_SO), 32'd1);
    check_eq("t5_outs", {bus.Res_Valid_SO, bus.Coef_Err_SO, bus.Mac_Clr_SO, bus.Mac_WrEn_SO,
                         bus.Mac_In0_DO, bus.Mac_In1_DO, bus.Res_DO}, 32'd0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.Res_Valid_SO) seen++;
    end
    check_eq("t5_no_result", 32'(seen), 32'd0);
    run_sample(8'h40, 1'b0, 3'd0, 8'h00, -1, 0, 1'b0, res);
    check_eq("t5_coef_cleared", 32'(res), 32'h00);

`ifdef MAC_SEQ_FLUSH_EN
    for (int k = 0; k < int'(TAPS); k++) write_coef(3'(k), 8'h40);
    run_sample(8'h80, 1'b0, 3'd0, 8'h00, -1, 0, 1'b0, res);
    run_sample(8'hC0, 1'b0, 3'd0, 8'h00, -1, 0, 1'b0, res);
    flush = 1'b1; bus.Smp_Valid_SI = 1'b1; bus.Smp_DI = 8'h55;
    check_eq("t6_flush_ready", 32'(bus.Smp_Ready_SO), 32'd0);
    @(negedge clk);
    flush = 1'b0; bus.Smp_Valid_SI = 1'b0;
    for (int k = 0; k < int'(TAPS); k++) ref_tap[k] = '0;
    run_sample(8'h40, 1'b0, 3'd0, 8'h00, -1, 0, 1'b0, res);
    check_eq("t6_res", 32'(res), 32'h10);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
